// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus scheduler: register map, field indices,
// transaction phase and batch type encodings.
package rtc_pkg;

    localparam int NUM_FIELDS = 9;

    typedef enum logic [3:0] {
        IDX_ANO      = 4'd0,
        IDX_MES      = 4'd1,
        IDX_DIA      = 4'd2,
        IDX_HORAS    = 4'd3,
        IDX_MINUTOS  = 4'd4,
        IDX_SEGUNDOS = 4'd5,
        IDX_HT       = 4'd6,
        IDX_MT       = 4'd7,
        IDX_ST       = 4'd8
    } field_idx_t;

    localparam logic [7:0] RTC_ADDR [0:NUM_FIELDS-1] = '{
        8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41
    };

    typedef enum logic [2:0] {
        IDLE,
        A_SETUP,
        A_STB,
        A_HOLD,
        D_SETUP,
        D_STB,
        D_HOLD
    } phase_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } batch_t;

    // Out-of-range indices map to 0x00 so the bus never sees a stray address.
    function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
        logic [7:0] a;
        a = 8'h00;
        if (idx <= IDX_ST) begin
            a = RTC_ADDR[idx];
        end
        return a;
    endfunction

endpackage

// File: rtl/rtc_bus_phase.sv
// Runs one address/data transaction on the multiplexed RTC bus; each of the
// six phases lasts T_PH cycles and a new start in the last D_HOLD cycle chains.
module rtc_bus_phase
    import rtc_pkg::*;
#(
    parameter int T_PH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dir_wr,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] ad_in,
    output logic       done,
    output logic [7:0] rdata,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad
);

    localparam int CW = (T_PH > 1) ? $clog2(T_PH) : 1;

    phase_t        state;
    phase_t        state_next;
    logic [CW-1:0] ph_cnt;
    logic          ph_last;

    assign ph_last = (ph_cnt == CW'(T_PH - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ph_cnt <= '0;
            rdata  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE || ph_last) begin
                ph_cnt <= '0;
            end else begin
                ph_cnt <= ph_cnt + CW'(1);
            end
            if (state == D_STB && ph_last && !dir_wr) begin
                rdata <= ad_in;
            end
        end
    end

    // NOTE: every output gets a default before the case so no path can
    // infer a latch.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        ad_out     = 8'h00;
        ad_oe      = 1'b0;
        cs_n       = 1'b1;
        rd_n       = 1'b1;
        wr_n       = 1'b1;
        ad         = 1'b1;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = A_SETUP;
                end
            end
            A_SETUP: begin
                cs_n   = 1'b0;
                ad     = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr;
                if (ph_last) begin
                    state_next = A_STB;
                end
            end
            A_STB: begin
                cs_n   = 1'b0;
                ad     = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr;
                wr_n   = 1'b0;
                if (ph_last) begin
                    state_next = A_HOLD;
                end
            end
            A_HOLD: begin
                cs_n   = 1'b0;
                ad     = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr;
                if (ph_last) begin
                    state_next = D_SETUP;
                end
            end
            D_SETUP: begin
                cs_n   = 1'b0;
                ad_oe  = dir_wr;
                ad_out = dir_wr ? wdata : 8'h00;
                if (ph_last) begin
                    state_next = D_STB;
                end
            end
            D_STB: begin
                cs_n   = 1'b0;
                ad_oe  = dir_wr;
                ad_out = dir_wr ? wdata : 8'h00;
                wr_n   = ~dir_wr;
                rd_n   = dir_wr;
                if (ph_last) begin
                    state_next = D_HOLD;
                end
            end
            D_HOLD: begin
                cs_n   = 1'b0;
                ad_oe  = dir_wr;
                ad_out = dir_wr ? wdata : 8'h00;
                if (ph_last) begin
                    done       = 1'b1;
                    state_next = start ? A_SETUP : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates PicoBlaze write batches against periodic read batches on the RTC
// bus and keeps the write/read shadows, field index and refresh timer.
module rtc_bus_scheduler
    import rtc_pkg::*;
#(
    parameter int T_PH        = 2,
    parameter int READ_PERIOD = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_wr,
    input  logic [71:0] wr_data,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    output logic        cs_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        ad,
    output logic [71:0] rd_data,
    output logic        rd_valid,
    output logic        listo_es,
    output logic        busy
);

    localparam int PW = (READ_PERIOD > 1) ? $clog2(READ_PERIOD) : 1;

    logic [PW-1:0] period_cnt;
    logic          period_wrap;
    logic          start_wr_q;
    logic          wr_edge;
    logic          wr_pend;
    logic          rd_pend;
    batch_t        dir_q;
    logic [3:0]    idx;
    logic [71:0]   wr_shadow;
    logic [71:0]   rd_shadow;
    logic [71:0]   rd_next;
    logic          launch;
    logic          last_txn;
    logic          phase_start;
    logic          phase_done;
    logic [7:0]    phase_rdata;
    logic [7:0]    txn_wdata;

    assign period_wrap = (period_cnt == PW'(READ_PERIOD - 1));
    assign wr_edge     = start_wr & ~start_wr_q;
    assign launch      = ~busy & (wr_pend | rd_pend);
    assign last_txn    = (idx == IDX_ST);
    assign phase_start = launch | (phase_done & ~last_txn);
    assign txn_wdata   = wr_shadow[{idx, 3'b000} +: 8];

    // Read shadow with the byte just finished merged in, so the final
    // transaction lands in rd_data on the same edge as the rest.
    always_comb begin
        rd_next                     = rd_shadow;
        rd_next[{idx, 3'b000} +: 8] = phase_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_cnt <= '0;
        end else if (period_wrap) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_wr_q <= 1'b0;
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            dir_q      <= RD;
            idx        <= '0;
            wr_shadow  <= '0;
            rd_shadow  <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            listo_es   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            start_wr_q <= start_wr;
            rd_valid   <= 1'b0;

            if (!start_wr || wr_edge) begin
                listo_es <= 1'b0;
            end

            if (launch) begin
                busy <= 1'b1;
                idx  <= IDX_ANO;
                if (wr_pend) begin
                    dir_q     <= WR;
                    wr_pend   <= 1'b0;
                    wr_shadow <= wr_data;
                end else begin
                    dir_q   <= RD;
                    rd_pend <= 1'b0;
                end
            end else if (phase_done) begin
                if (dir_q == RD) begin
                    rd_shadow <= rd_next;
                end
                if (last_txn) begin
                    busy <= 1'b0;
                    idx  <= IDX_ANO;
                    if (dir_q == RD) begin
                        rd_data  <= rd_next;
                        rd_valid <= 1'b1;
                    end else begin
                        listo_es <= 1'b1;
                    end
                end else begin
                    idx <= idx + 4'd1;
                end
            end

            // NOTE: the last non-blocking assignment to a flop wins, so a
            // request arriving on the launch edge survives the clear above.
            if (wr_edge) begin
                wr_pend <= 1'b1;
            end
            if (period_wrap) begin
                rd_pend <= 1'b1;
            end
        end
    end

    rtc_bus_phase #(
        .T_PH (T_PH)
    ) u_phase (
        .clk    (clk),
        .reset  (reset),
        .start  (phase_start),
        .dir_wr (dir_q == WR),
        .addr   (rtc_addr(idx)),
        .wdata  (txn_wdata),
        .ad_in  (ad_in),
        .done   (phase_done),
        .rdata  (phase_rdata),
        .ad_out (ad_out),
        .ad_oe  (ad_oe),
        .cs_n   (cs_n),
        .rd_n   (rd_n),
        .wr_n   (wr_n),
        .ad     (ad)
    );

endmodule

// File: doc/rtc_bus_scheduler.md
# rtc_bus_scheduler

Sequences all traffic on the external RTC's multiplexed address/data bus. Arbitrates between PicoBlaze-initiated write batches (date, time and timer fields held in the port register bank) and periodic read batches that refresh the RTC snapshot returned to the PicoBlaze. Sits between the PicoBlaze port register bank and the top-level tristate pad for the RTC bus.

## Interface
- `T_PH`, default 2: clock cycles per bus phase; must be ≥1.
- `READ_PERIOD`, default 1_000_000: clock cycles between periodic read requests; must be ≥2.
- `clk` in 1: single system clock; everything is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start_wr` in 1: write request level (Listo_ht from the register bank); its rising edge requests a write batch.
- `wr_data` in 72: write fields; byte k = `wr_data[8k+7:8k]`, k=0..8 = ano, mes, dia, horas, minutos, segundos, ht, mt, st.
- `ad_in` in 8: bus value read back from the pad.
- `ad_out` out 8: bus drive value.
- `ad_oe` out 1: pad output enable.
- `cs_n`, `rd_n`, `wr_n` out 1 each: RTC strobes, active-low.
- `ad` out 1: 0 = address phase, 1 = data phase.
- `rd_data` out 72: last complete read snapshot, same byte order as `wr_data`.
- `rd_valid` out 1: one-cycle pulse when `rd_data` updates.
- `listo_es` out 1: write batch complete (Listo_es to the register bank).
- `busy` out 1: a batch is in progress.

## Operation
- Reset values: `cs_n`, `rd_n`, `wr_n` and `ad` are 1. `ad_oe`, `ad_out`, `rd_data`, `rd_valid`, `listo_es` and `busy` are 0. Pending flags, the field index, the phase counter and the period counter are 0. FSM state is IDLE.
- Period counter counts 0..READ_PERIOD-1 continuously, including while busy. On wrap it sets `rd_pend`. Repeated wraps before service coalesce into one request.
- A rising edge on `start_wr` (previous-cycle sample 0, current 1) sets `wr_pend`. The edge also clears `listo_es`. When `start_wr` is sampled low, `listo_es` clears.
- Arbitration happens only in IDLE, only at batch boundaries, and never preempts a batch.
  - `wr_pend` has priority over `rd_pend`.
  - Starting a batch clears its pending flag and sets `busy`.
- Write batch start: `wr_data` is snapshotted into a 72-bit shadow. Later changes to `wr_data` do not affect the batch.
- A batch runs 9 transactions, field index k=0..8, at address RTC_ADDR[k] = 0x26, 0x25, 0x24, 0x23, 0x22, 0x21, 0x43, 0x42, 0x41.
- Per-transaction FSM; each state lasts exactly T_PH cycles; `cs_n`=0 throughout:
  - A_SETUP: `ad`=0, `ad_oe`=1, `ad_out`=addr.
  - A_STB: as A_SETUP, plus `wr_n`=0.
  - A_HOLD: `wr_n`=1, address still driven.
  - D_SETUP: `ad`=1. Write: `ad_oe`=1, `ad_out`=shadow byte k. Read: `ad_oe`=0, `ad_out`=0.
  - D_STB: write drives `wr_n`=0; read drives `rd_n`=0. On a read, `ad_in` is captured into read-shadow byte k on the last cycle of D_STB.
  - D_HOLD: strobes 1. Data still driven on a write.
  - Then k+1 → A_SETUP. After k=8 → IDLE, where `cs_n`=1 and `ad_oe`=0.
- Read batch end: the read shadow is copied to `rd_data` in one cycle and `rd_valid` pulses. `rd_data` never shows a partially updated snapshot.
- Write batch end: `listo_es` is set; it holds until cleared as described above. A write batch never changes `rd_data`.
- Requests arriving during a batch set their pending flag and are served at the next IDLE.
- Reset asserted mid-batch: strobes are released immediately, nothing is committed, and pending requests are lost.

## Timing
- One transaction takes 6·T_PH cycles. One batch takes 54·T_PH cycles plus 1 IDLE cycle before the next batch can start.
- Request to bus activity: a request registered in cycle n while IDLE gives `cs_n`=0 in cycle n+1.
- `busy` is 1 from the first A_SETUP cycle through the last D_HOLD cycle.
- `rd_valid` and the `rd_data` update occur on the cycle after the last D_HOLD.
- `listo_es` rises on the cycle after the last D_HOLD.
- `ad_out` and `ad_oe` change only on state boundaries.
- Strobe low time is exactly T_PH cycles. Setup and hold to the strobe are each T_PH cycles.

## Structure
- Shared package `rtc_pkg`:
  - RTC_ADDR[0:8] constants and field index names (IDX_ANO..IDX_ST).
  - Phase state enum: IDLE, A_SETUP, A_STB, A_HOLD, D_SETUP, D_STB, D_HOLD.
  - Batch type enum: RD, WR.
- One natural sub-module, `rtc_bus_phase`: runs a single transaction (addr, wdata, dir, start → done, rdata, pins). The top holds arbitration, the period counter, the shadows and the field index.

## Test plan
- Reset with all outputs checked at reset values. Release reset, then pulse `start_wr` with `wr_data` bytes ano..st = 0x24, 0x05, 0x17, 0x13, 0x45, 0x30, 0x01, 0x02, 0x03 (T_PH=2). Expect 9 address/data pairs: 0x26/0x24 … 0x41/0x03, each `wr_n` low 2 cycles. `listo_es`=1 at cycle 109; it clears after `start_wr` falls.
- READ_PERIOD=200, bus model returning 0x80|k on data reads. At counter wrap, 9 read transactions run. `rd_data` byte k = 0x80|k, appearing in one cycle together with a single `rd_valid` pulse. `rd_data` is unchanged before that cycle.
- `start_wr` edge during transaction 3 of a read batch: the read batch completes unaltered, then the write batch starts 1 cycle after IDLE.
- `wr_pend` and `rd_pend` both set in IDLE: write is served first, then the read.
- Change `wr_data` mid write batch: bus data still equals the start-of-batch values.
- Assert `reset` during a read D_STB: `cs_n`/`rd_n` go to 1 asynchronously, `rd_data` stays 0, and no `rd_valid`.
